// File: rtl/min_window_tracker.sv
// min_window_tracker
// Streaming stage that sits behind the external 3-bit min comparator. Each
// accepted sample is presented to the comparator together with the running
// minimum, and the comparator result is registered as the new running minimum.
// After FRAME_LEN samples, or an early flush, the frame minimum and sample
// count are presented on a valid/ready result port and held until taken.

module min_window_tracker #(
    parameter int WIDTH     = 3,   // must match the comparator width (3)
    parameter int FRAME_LEN = 8    // samples per frame, 1..255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic [WIDTH-1:0] cmp_a,
    output logic [WIDTH-1:0] cmp_b,
    input  logic [WIDTH-1:0] cmp_min,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_min,
    output logic [7:0]       out_count
);

    // Frame length as an 8-bit value so it compares directly with the counter.
    localparam logic [7:0]       FRAME_LEN_C = 8'(FRAME_LEN);
    // All-ones is the identity for a minimum, so an empty frame starts there.
    localparam logic [WIDTH-1:0] MIN_INIT_C  = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] run_min_r;
    logic [WIDTH-1:0] run_min_s;
    logic [7:0]       cnt_r;
    logic [7:0]       cnt_s;
    logic             out_valid_r;
    logic             out_valid_s;
    logic [WIDTH-1:0] out_min_r;
    logic [WIDTH-1:0] out_min_s;
    logic [7:0]       out_count_r;
    logic [7:0]       out_count_s;

    logic             in_ready_s;
    logic             accept_s;
    logic [WIDTH-1:0] fold_min_s;
    logic [7:0]       fold_cnt_s;

    // True when a count value closes the frame.
    function automatic logic frame_full(input logic [7:0] count);
        frame_full = (count == FRAME_LEN_C);
    endfunction

    // Handshake and comparator feed: the sample goes to A, the running min to B.
    always_comb begin
        in_ready_s = (state_r != DONE);
        accept_s   = in_valid & in_ready_s;
        cmp_a      = in_data;
        cmp_b      = run_min_r;
    end

    // Running min and count after folding in this cycle's sample, if any.
    always_comb begin
        if (accept_s) begin
            fold_min_s = cmp_min;
            fold_cnt_s = cnt_r + 8'd1;
        end else begin
            fold_min_s = run_min_r;
            fold_cnt_s = cnt_r;
        end
    end

    // Next-state and next-register logic for the frame FSM.
    always_comb begin
        state_s     = state_r;
        run_min_s   = run_min_r;
        cnt_s       = cnt_r;
        out_valid_s = out_valid_r;
        out_min_s   = out_min_r;
        out_count_s = out_count_r;

        case (state_r)
            IDLE: begin
                // The first sample starts the frame directly; the comparator is
                // bypassed so the frame does not depend on the previous run_min.
                // flush has no effect on an empty frame.
                if (accept_s) begin
                    run_min_s = in_data;
                    cnt_s     = 8'd1;
                    if (frame_full(8'd1)) begin
                        state_s     = DONE;
                        out_valid_s = 1'b1;
                        out_min_s   = in_data;
                        out_count_s = 8'd1;
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = IDLE;
                end
            end

            ACCUM: begin
                // A sample arriving together with flush is folded in first.
                run_min_s = fold_min_s;
                cnt_s     = fold_cnt_s;
                if (flush || (accept_s && frame_full(fold_cnt_s))) begin
                    state_s     = DONE;
                    out_valid_s = 1'b1;
                    out_min_s   = fold_min_s;
                    out_count_s = fold_cnt_s;
                end else begin
                    state_s = ACCUM;
                end
            end

            DONE: begin
                // Result is held until taken; the running state is cleared on the
                // handshake so the next frame starts from an empty window.
                if (out_ready) begin
                    state_s     = IDLE;
                    out_valid_s = 1'b0;
                    run_min_s   = MIN_INIT_C;
                    cnt_s       = 8'd0;
                end else begin
                    state_s = DONE;
                end
            end

            default: begin
                state_s     = IDLE;
                run_min_s   = MIN_INIT_C;
                cnt_s       = 8'd0;
                out_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            run_min_r   <= MIN_INIT_C;
            cnt_r       <= 8'd0;
            out_valid_r <= 1'b0;
            out_min_r   <= MIN_INIT_C;
            out_count_r <= 8'd0;
        end else begin
            state_r     <= state_s;
            run_min_r   <= run_min_s;
            cnt_r       <= cnt_s;
            out_valid_r <= out_valid_s;
            out_min_r   <= out_min_s;
            out_count_r <= out_count_s;
        end
    end

    // Result port is driven straight from registers.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = out_valid_r;
        out_min   = out_min_r;
        out_count = out_count_r;
    end

endmodule

// File: tb/tb_min_window_tracker.sv
// Testbench for min_window_tracker: an 8-sample instance and a 1-sample
// instance, each with a behavioural min comparator. Expected frame results
// are queued when a frame is driven and popped when the result appears.

module tb_min_window_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, flush, out_ready;
    logic [2:0] in_data;
    logic       in_ready, out_valid;
    logic [2:0] cmp_a, cmp_b, cmp_min, out_min;
    logic [7:0] out_count;

    logic       in_valid1, flush1, out_ready1;
    logic [2:0] in_data1;
    logic       in_ready1, out_valid1;
    logic [2:0] cmp_a1, cmp_b1, cmp_min1, out_min1;
    logic [7:0] out_count1;

    typedef struct packed {
        logic [2:0] m;
        logic [7:0] c;
    } res_t;

    res_t sb_q[$];
    res_t exp_r;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    // Behavioural models of the external comparator.
    assign cmp_min  = (cmp_a  < cmp_b)  ? cmp_a  : cmp_b;
    assign cmp_min1 = (cmp_a1 < cmp_b1) ? cmp_a1 : cmp_b1;

    min_window_tracker #(.WIDTH(3), .FRAME_LEN(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_min(cmp_min), .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_count(out_count)
    );

    min_window_tracker #(.WIDTH(3), .FRAME_LEN(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data1), .flush(flush1), .cmp_a(cmp_a1), .cmp_b(cmp_b1),
        .cmp_min(cmp_min1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_min(out_min1), .out_count(out_count1)
    );

    task automatic feed(input logic [2:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic feed_frame(input logic [2:0] s0, s1, s2, s3, s4, s5, s6, s7);
        feed(s0); feed(s1); feed(s2); feed(s3);
        feed(s4); feed(s5); feed(s6); feed(s7);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Pops the next expected result; an empty queue counts as a mismatch.
    task automatic pop_expected(input string tag);
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $display("FAIL %s_sb got empty queue want one entry", tag);
            exp_r = '0;
        end else begin
            exp_r = sb_q.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_data = 3'd5;
        #1;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", out_valid); end
        compared++; if (out_min !== 3'd7) begin mismatched++; $display("FAIL rst_min got %0d want 7", out_min); end
        compared++; if (out_count !== 8'd0) begin mismatched++; $display("FAIL rst_count got %0d want 0", out_count); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rst_ready got %b want 1", in_ready); end
        compared++; if (cmp_b !== 3'd7) begin mismatched++; $display("FAIL rst_cmpb got %0d want 7", cmp_b); end
        compared++; if (cmp_a !== 3'd5) begin mismatched++; $display("FAIL rst_cmpa got %0d want 5", cmp_a); end
        @(negedge clk);
    endtask

    task automatic test_basic_frame();
        sb_q.push_back('{m: 3'd2, c: 8'd8});
        feed(3'd5); feed(3'd3);
        compared++; if (cmp_b !== 3'd3) begin mismatched++; $display("FAIL t1_runmin got %0d want 3", cmp_b); end
        feed(3'd6); feed(3'd7); feed(3'd2); feed(3'd4); feed(3'd6);
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL t1_early_valid got %b want 0", out_valid); end
        feed(3'd5);
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t1_valid got %b want 1", out_valid); end
        pop_expected("t1");
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t1_min got %0d want %0d", out_min, exp_r.m); end
        compared++; if (out_count !== exp_r.c) begin mismatched++; $display("FAIL t1_count got %0d want %0d", out_count, exp_r.c); end
        drain();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL t1_release got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL t1_idle_ready got %b want 1", in_ready); end
    endtask

    task automatic test_min_reinit();
        sb_q.push_back('{m: 3'd7, c: 8'd8});
        feed_frame(3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7);
        pop_expected("t2a");
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t2a_valid got %b want 1", out_valid); end
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t2a_min got %0d want %0d", out_min, exp_r.m); end
        drain();
        sb_q.push_back('{m: 3'd0, c: 8'd8});
        feed_frame(3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
        pop_expected("t2b");
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t2b_min got %0d want %0d", out_min, exp_r.m); end
        compared++; if (out_count !== exp_r.c) begin mismatched++; $display("FAIL t2b_count got %0d want %0d", out_count, exp_r.c); end
        drain();
        // Next frame after a zero frame must not inherit the zero.
        sb_q.push_back('{m: 3'd4, c: 8'd8});
        feed_frame(3'd6, 3'd4, 3'd5, 3'd7, 3'd6, 3'd4, 3'd5, 3'd6);
        pop_expected("t2c");
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t2c_min got %0d want %0d", out_min, exp_r.m); end
        drain();
    endtask

    task automatic test_flush();
        // flush in IDLE does nothing
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL t3_idle_flush got %b want 0", out_valid); end
        sb_q.push_back('{m: 3'd1, c: 8'd3});
        feed(3'd4); feed(3'd1); feed(3'd6);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        pop_expected("t3a");
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t3a_valid got %b want 1", out_valid); end
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t3a_min got %0d want %0d", out_min, exp_r.m); end
        compared++; if (out_count !== exp_r.c) begin mismatched++; $display("FAIL t3a_count got %0d want %0d", out_count, exp_r.c); end
        drain();
        sb_q.push_back('{m: 3'd0, c: 8'd4});
        feed(3'd4); feed(3'd1); feed(3'd6);
        in_valid = 1'b1; in_data = 3'd0; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        pop_expected("t3b");
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t3b_valid got %b want 1", out_valid); end
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t3b_min got %0d want %0d", out_min, exp_r.m); end
        compared++; if (out_count !== exp_r.c) begin mismatched++; $display("FAIL t3b_count got %0d want %0d", out_count, exp_r.c); end
        drain();
    endtask

    task automatic test_backpressure();
        sb_q.push_back('{m: 3'd2, c: 8'd8});
        feed_frame(3'd5, 3'd3, 3'd6, 3'd7, 3'd2, 3'd4, 3'd6, 3'd5);
        pop_expected("t4");
        in_valid = 1'b1; in_data = 3'd0; flush = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL t4_ready[%0d] got %b want 0", i, in_ready); end
            compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t4_valid[%0d] got %b want 1", i, out_valid); end
            compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t4_min[%0d] got %0d want %0d", i, out_min, exp_r.m); end
            compared++; if (out_count !== exp_r.c) begin mismatched++; $display("FAIL t4_count[%0d] got %0d want %0d", i, out_count, exp_r.c); end
        end
        in_valid = 1'b0; flush = 1'b0;
        drain();
        compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL t4_release got %b want 0", out_valid); end
        compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL t4_idle got %b want 1", in_ready); end
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t4_hold_min got %0d want %0d", out_min, exp_r.m); end
        compared++; if (out_count !== exp_r.c) begin mismatched++; $display("FAIL t4_hold_count got %0d want %0d", out_count, exp_r.c); end
    endtask

    task automatic test_reset_midframe();
        feed(3'd1); feed(3'd1); feed(3'd2); feed(3'd0); feed(3'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL t5_valid[%0d] got %b want 0", i, out_valid); end
            @(negedge clk);
        end
        compared++; if (out_count !== 8'd0) begin mismatched++; $display("FAIL t5_count_rst got %0d want 0", out_count); end
        compared++; if (cmp_b !== 3'd7) begin mismatched++; $display("FAIL t5_runmin_rst got %0d want 7", cmp_b); end
        sb_q.push_back('{m: 3'd3, c: 8'd8});
        feed_frame(3'd6, 3'd5, 3'd4, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6);
        pop_expected("t5");
        compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t5_frame_valid got %b want 1", out_valid); end
        compared++; if (out_min !== exp_r.m) begin mismatched++; $display("FAIL t5_min got %0d want %0d", out_min, exp_r.m); end
        compared++; if (out_count !== exp_r.c) begin mismatched++; $display("FAIL t5_count got %0d want %0d", out_count, exp_r.c); end
        drain();
    endtask

    task automatic test_frame_len_one();
        sb_q.push_back('{m: 3'd2, c: 8'd1});
        in_valid1 = 1'b1; in_data1 = 3'd2;
        @(negedge clk);
        in_valid1 = 1'b0;
        pop_expected("t6");
        compared++; if (out_valid1 !== 1'b1) begin mismatched++; $display("FAIL t6_valid got %b want 1", out_valid1); end
        compared++; if (in_ready1 !== 1'b0) begin mismatched++; $display("FAIL t6_ready got %b want 0", in_ready1); end
        compared++; if (out_min1 !== exp_r.m) begin mismatched++; $display("FAIL t6_min got %0d want %0d", out_min1, exp_r.m); end
        compared++; if (out_count1 !== exp_r.c) begin mismatched++; $display("FAIL t6_count got %0d want %0d", out_count1, exp_r.c); end
        out_ready1 = 1'b1;
        @(negedge clk);
        out_ready1 = 1'b0;
        compared++; if (out_valid1 !== 1'b0) begin mismatched++; $display("FAIL t6_release got %b want 0", out_valid1); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 3'd0;
        in_valid1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b0; in_data1 = 3'd0;
        test_reset();
        test_basic_frame();
        test_min_reinit();
        test_flush();
        test_backpressure();
        test_reset_midframe();
        test_frame_len_one();
        compared++;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover got %0d entries want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
